// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key sync/debounce/press detect, mode FSM, centisecond prescaler.
// Latency: key edge -> press pulse 2 sync + DEBOUNCE_CYCLES cycles; press -> state/outputs +1 cycle.
// Backpressure: none; the downstream counter must accept every count_en/count_clr pulse.
module stopwatch_ctrl #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [2:0] key_n,
    output logic       count_en,
    output logic       count_clr,
    output logic       disp_hold,
    output logic [1:0] state
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_db_lvl;
    logic [2:0]    r_db_lvl_d;
    logic [DW-1:0] r_db_cnt [3];
    logic [PW-1:0] r_pre;
    logic          r_count_en;
    logic          r_count_clr;
    state_t        r_state;
    state_t        w_next;
    logic          w_clr_next;
    logic [2:0]    w_press;
    logic          w_ev_clr;
    logic          w_ev_ss;
    logic          w_ev_lap;
    logic          w_counting;

    // Synchronize raw keys and accept a new level only after it has been stable long enough.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_db_lvl   <= '1;
            r_db_lvl_d <= '1;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1    <= key_n;
            r_sync2    <= r_sync1;
            r_db_lvl_d <= r_db_lvl;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_db_lvl[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press = debounced falling edge; releases are ignored.
    assign w_press = r_db_lvl_d & ~r_db_lvl;

    // One event per cycle: clear beats start/stop beats lap.
    assign w_ev_clr = w_press[2];
    assign w_ev_ss  = w_press[0] & ~w_press[2];
    assign w_ev_lap = w_press[1] & ~w_press[0] & ~w_press[2];

    assign w_counting = (r_state == ST_RUN) || (r_state == ST_LAP);

    // Mode transitions and the clear request that goes with a return to IDLE.
    always_comb begin
        w_next     = r_state;
        w_clr_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ev_clr)     w_clr_next = 1'b1;
                else if (w_ev_ss) w_next     = ST_RUN;
            end
            ST_RUN: begin
                if (w_ev_ss)       w_next = ST_PAUSE;
                else if (w_ev_lap) w_next = ST_LAP;
            end
            ST_LAP: begin
                if (w_ev_ss)       w_next = ST_PAUSE;
                else if (w_ev_lap) w_next = ST_RUN;
            end
            ST_PAUSE: begin
                if (w_ev_clr) begin
                    w_next     = ST_IDLE;
                    w_clr_next = 1'b1;
                end else if (w_ev_ss) begin
                    w_next = ST_RUN;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register and registered clear pulse.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_count_clr <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_count_clr <= w_clr_next;
        end
    end

    // Prescaler runs only while counting and holds in PAUSE so the sub-tick phase survives a pause.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_pre      <= '0;
            r_count_en <= 1'b0;
        end else begin
            r_count_en <= w_counting && (r_pre == PRE_MAX);
            if (w_clr_next || (r_state == ST_IDLE)) begin
                r_pre <= '0;
            end else if (w_counting) begin
                r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
            end
        end
    end

    assign count_en  = r_count_en;
    assign count_clr = r_count_clr;
    assign disp_hold = (r_state == ST_LAP);
    assign state     = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DIV=10 and DEBOUNCE_CYCLES=4.
// Expected output events (cycle, state, pulses, hold) are queued by the stimulus;
// a negedge monitor pops one whenever the DUT shows a pulse or a state change.
module tb_stopwatch_ctrl;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       en;
        logic       clr;
        logic       hold;
    } ev_t;

    logic       clk;
    logic       reset;
    logic [2:0] key_n;
    logic       count_en;
    logic       count_clr;
    logic       disp_hold;
    logic [1:0] state;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   mon_on = 1'b0;
    logic [1:0] prev_st = 2'b00;
    ev_t  exp_q[$];
    ev_t  want_e;

    stopwatch_ctrl #(
        .CLK_HZ         (1000),
        .TICK_HZ        (100),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .key_n    (key_n),
        .count_en (count_en),
        .count_clr(count_clr),
        .disp_hold(disp_hold),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [1:0] st, input logic en, input logic clr, input logic hold);
        ev_t e;
        e.cyc = c; e.st = st; e.en = en; e.clr = clr; e.hold = hold;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cyc=%0d)", name, got, want, cyc);
        end
    endtask

    // Hold the masked keys low for n cycles, starting at the current negedge.
    task automatic press(input logic [2:0] mask, input int n);
        key_n = key_n & ~mask;
        repeat (n) @(negedge clk);
        key_n = key_n | mask;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every cycle with a pulse or a state change must match the head of the queue.
    always @(negedge clk) begin
        if (mon_on && (count_en || count_clr || (state != prev_st))) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: cyc=%0d st=%0d en=%0b clr=%0b hold=%0b, expected none",
                         cyc, state, count_en, count_clr, disp_hold);
            end else begin
                want_e = exp_q.pop_front();
                if (want_e.cyc != cyc || want_e.st !== state || want_e.en !== count_en ||
                    want_e.clr !== count_clr || want_e.hold !== disp_hold) begin
                    bad++;
                    $display("FAIL event: got cyc=%0d st=%0d en=%0b clr=%0b hold=%0b, expected cyc=%0d st=%0d en=%0b clr=%0b hold=%0b",
                             cyc, state, count_en, count_clr, disp_hold,
                             want_e.cyc, want_e.st, want_e.en, want_e.clr, want_e.hold);
                end
            end
        end
        prev_st = state;
    end

    initial begin
        int t;
        int e;
        reset = 1'b1;
        key_n = 3'b111;
        repeat (5) @(negedge clk);
        chk("rst_state", state, 2'd0);
        chk("rst_en", {1'b0, count_en}, 2'd0);
        chk("rst_clr", {1'b0, count_clr}, 2'd0);
        chk("rst_hold", {1'b0, disp_hold}, 2'd0);
        reset = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_state", state, 2'd0);
        chk("idle_en", {1'b0, count_en}, 2'd0);
        chk("idle_clr", {1'b0, count_clr}, 2'd0);
        chk("idle_hold", {1'b0, disp_hold}, 2'd0);

        // 3-cycle glitches on start/stop: no event may appear.
        for (int i = 0; i < 3; i++) begin
            press(3'b001, 3);
            repeat (5) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("glitch_state", state, 2'd0);

        // Lap in IDLE is ignored.
        press(3'b010, 4);
        repeat (15) @(negedge clk);
        chk("idle_lap_state", state, 2'd0);

        // Clear in IDLE: count_clr pulse 7 cycles after the key is driven low, state stays IDLE.
        t = cyc;
        push(t + 7, 2'd0, 1'b0, 1'b1, 1'b0);
        press(3'b100, 4);
        repeat (15) @(negedge clk);

        // Main sequence; e is the cycle the state enters RUN.
        t = cyc;
        e = t + 7;
        push(e,       2'd1, 1'b0, 1'b0, 1'b0);
        push(e + 10,  2'd1, 1'b1, 1'b0, 1'b0);
        push(e + 20,  2'd1, 1'b1, 1'b0, 1'b0);
        push(e + 22,  2'd3, 1'b0, 1'b0, 1'b1);
        push(e + 30,  2'd3, 1'b1, 1'b0, 1'b1);
        push(e + 40,  2'd3, 1'b1, 1'b0, 1'b1);
        push(e + 42,  2'd1, 1'b0, 1'b0, 1'b0);
        push(e + 50,  2'd1, 1'b1, 1'b0, 1'b0);
        push(e + 56,  2'd2, 1'b0, 1'b0, 1'b0);
        push(e + 77,  2'd1, 1'b0, 1'b0, 1'b0);
        push(e + 81,  2'd1, 1'b1, 1'b0, 1'b0);
        push(e + 91,  2'd1, 1'b1, 1'b0, 1'b0);
        push(e + 93,  2'd2, 1'b0, 1'b0, 1'b0);
        push(e + 112, 2'd0, 1'b0, 1'b1, 1'b0);
        push(e + 132, 2'd1, 1'b0, 1'b0, 1'b0);
        push(e + 142, 2'd1, 1'b1, 1'b0, 1'b0);
        push(e + 147, 2'd0, 1'b0, 1'b0, 1'b0);

        press(3'b001, 8);             // start, 8-cycle low
        wait_until(e + 15);
        press(3'b010, 4);             // lap -> LAP
        wait_until(e + 35);
        press(3'b010, 4);             // lap -> RUN
        wait_until(e + 49);
        press(3'b001, 4);             // pause with prescaler held at 6
        wait_until(e + 70);
        press(3'b001, 4);             // resume: first tick 4 cycles later
        wait_until(e + 86);
        press(3'b001, 4);             // pause again
        wait_until(e + 105);
        press(3'b101, 4);             // start/stop and clear together: clear wins
        wait_until(e + 125);
        press(3'b001, 8);             // start again from IDLE
        wait_until(e + 146);
        reset = 1'b1;                 // reset mid-RUN: no count_clr
        wait_until(e + 150);
        chk("midrst_state", state, 2'd0);
        chk("midrst_clr", {1'b0, count_clr}, 2'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("final_state", state, 2'd0);
        chk("final_hold", {1'b0, disp_hold}, 2'd0);

        while (exp_q.size() > 0) begin
            want_e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event: got nothing, expected cyc=%0d st=%0d en=%0b clr=%0b hold=%0b",
                     want_e.cyc, want_e.st, want_e.en, want_e.clr, want_e.hold);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
